// File: rtl/word_link_pkg.sv
// Shared serial-link definitions: frame state encoding, word geometry, line levels.
// Used by both the word transmitter and the matching receiver.
package word_link_pkg;

    localparam int WORD_W    = 16;
    localparam int BIT_CNT_W = 4;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/word_tx_16bit_chip_bit_tick_divider.sv
// Modulo-CLKS_PER_BIT counter; tick is combinational at terminal count while enabled.
// No handshake: clr wins over en, and the count holds while en is low.
module bit_tick_divider #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/word_tx_16bit_chip.sv
// Serial word transmitter: start, 16 data bits LSB-first, optional even parity, stop.
// tx_line lags the accept edge by one clock; in_ready is low for the whole frame.
module word_tx_16bit_chip
    import word_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_line,
    output logic              busy
);
    link_state_t           state;
    logic [WORD_W-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  parity_bit;
    logic                  tick;
    logic                  accept;

    assign busy     = (state != IDLE);
    assign in_ready = ~busy;
    assign accept   = in_valid && in_ready;

    // Divider is held at zero in IDLE so every START begins a fresh bit period.
    bit_tick_divider #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_div (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (busy),
        .clr    (state == IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tx_line    <= IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    tx_line <= IDLE_LEVEL;
                    if (accept) begin
                        shift_reg  <= in_word;
                        parity_bit <= even_parity(in_word);
                        bit_cnt    <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    tx_line <= START_LEVEL;
                    if (tick) state <= DATA;
                end
                DATA: begin
                    tx_line <= shift_reg[0];
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_CNT_W'(WORD_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    tx_line <= parity_bit;
                    if (tick) state <= STOP;
                end
                STOP: begin
                    tx_line <= STOP_LEVEL;
                    if (tick) state <= IDLE;
                end
                default: begin
                    tx_line <= IDLE_LEVEL;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_tx_16bit_chip.sv
// Bench for word_tx_16bit_chip: parity and no-parity instances against a frame-level model.
module tb_word_tx_16bit_chip;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] in_word = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_valid_np = 1'b0;
    logic        in_ready, tx_line, busy;
    logic        in_ready_np, tx_line_np, busy_np;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_tx_16bit_chip #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .tx_line(tx_line), .busy(busy)
    );

    word_tx_16bit_chip #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_valid(in_valid_np),
        .in_ready(in_ready_np), .tx_line(tx_line_np), .busy(busy_np)
    );

    function automatic int frame_len(input bit p);
        return (18 + (p ? 1 : 0)) * CPB;
    endfunction

    // Sample i (taken at the i-th falling edge after the accept edge) shows slot (i-1)/CPB.
    function automatic logic [0:127] exp_stream(input logic [15:0] w, input bit p);
        logic [0:127] v;
        bit q[$];
        int ones;
        int len;
        v = '0;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 16; i++) begin
            q.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (p) q.push_back((ones % 2) == 1);
        q.push_back(1'b1);
        len = frame_len(p);
        v[0] = 1'b1;
        for (int i = 1; i <= len; i++) v[i] = q[(i - 1) / CPB];
        return v;
    endfunction

    function automatic logic [0:127] exp_busy(input bit p);
        logic [0:127] v;
        v = '0;
        for (int i = 0; i < frame_len(p); i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:127] exp_ready(input bit p);
        logic [0:127] v;
        v = '0;
        v[frame_len(p)] = 1'b1;
        return v;
    endfunction

    task automatic accept_word(input logic [15:0] w, input bit np, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((np ? in_ready_np : in_ready) === 1'b1) begin
                in_word = w;
                if (np) in_valid_np = 1'b1; else in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_valid_np = 1'b0;
                ok = 1'b1;
            end
        end
    endtask

    task automatic capture(input bit np, input int len,
                           output logic [0:127] tx, output logic [0:127] bz, output logic [0:127] rd);
        tx = '0; bz = '0; rd = '0;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            tx[i] = np ? tx_line_np : tx_line;
            bz[i] = np ? busy_np : busy;
            rd[i] = np ? in_ready_np : in_ready;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        in_valid = 1'b1; in_valid_np = 1'b1; in_word = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tx_line !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || tx_line_np !== 1'b1 || busy_np !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: tx=%b ready=%b busy=%b tx_np=%b busy_np=%b, want 1 1 0 1 0",
                         tx_line, in_ready, busy, tx_line_np, busy_np);
            end
        end
        reset_n = 1'b1; in_valid = 1'b0; in_valid_np = 1'b0;
        #1;
        checks++;
        if (tx_line !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tx=%b ready=%b busy=%b, want 1 1 0", tx_line, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || busy_np !== 1'b0 || tx_line !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_frame: busy=%b busy_np=%b tx=%b, want 0 0 1", busy, busy_np, tx_line);
        end
    endtask

    task automatic test_single_frame();
        logic [0:127] tx, bz, rd;
        bit ok;
        accept_word(16'hA5C3, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: accepted=0 want 1"); end
        capture(1'b0, frame_len(1'b1), tx, bz, rd);
        checks++;
        if (tx !== exp_stream(16'hA5C3, 1'b1)) begin
            errors++;
            $display("FAIL single_stream: got %h want %h", tx, exp_stream(16'hA5C3, 1'b1));
        end
        checks++;
        if ($countones(bz) != 76 || bz !== exp_busy(1'b1)) begin
            errors++;
            $display("FAIL single_busy: got %0d busy cycles (%h) want 76", $countones(bz), bz);
        end
        checks++;
        if (rd !== exp_ready(1'b1)) begin
            errors++;
            $display("FAIL single_ready: got %h want %h", rd, exp_ready(1'b1));
        end
    endtask

    task automatic test_parity();
        logic [0:127] tx, bz, rd;
        bit ok;
        accept_word(16'h0001, 1'b0, ok);
        capture(1'b0, frame_len(1'b1), tx, bz, rd);
        checks++;
        if (!ok || tx[1 + 17*CPB] !== 1'b1 || tx !== exp_stream(16'h0001, 1'b1)) begin
            errors++;
            $display("FAIL parity_on_stream: parity=%b got %h want %h", tx[1 + 17*CPB], tx, exp_stream(16'h0001, 1'b1));
        end
        checks++;
        if ($countones(bz) != 76) begin
            errors++;
            $display("FAIL parity_on_len: got %0d want 76", $countones(bz));
        end
        accept_word(16'h0001, 1'b1, ok);
        capture(1'b1, frame_len(1'b0), tx, bz, rd);
        checks++;
        if (!ok || tx !== exp_stream(16'h0001, 1'b0)) begin
            errors++;
            $display("FAIL parity_off_stream: got %h want %h", tx, exp_stream(16'h0001, 1'b0));
        end
        checks++;
        if ($countones(bz) != 72 || bz !== exp_busy(1'b0)) begin
            errors++;
            $display("FAIL parity_off_len: got %0d want 72", $countones(bz));
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] tx1, bz1, rd1, tx2, bz2, rd2;
        int len, gap;
        len = frame_len(1'b1);
        @(negedge clk);
        in_word = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_word = 16'h0000;
        capture(1'b0, len, tx1, bz1, rd1);
        capture(1'b0, len, tx2, bz2, rd2);
        in_valid = 1'b0;
        checks++;
        if (tx1 !== exp_stream(16'hFFFF, 1'b1) || tx2 !== exp_stream(16'h0000, 1'b1)) begin
            errors++;
            $display("FAIL b2b_stream: got %h / %h", tx1, tx2);
        end
        checks++;
        if (bz1 !== exp_busy(1'b1) || bz2 !== exp_busy(1'b1)) begin
            errors++;
            $display("FAIL b2b_accept_gap: busy1=%h busy2=%h want %h", bz1, bz2, exp_busy(1'b1));
        end
        checks++;
        if (rd1 !== exp_ready(1'b1) || rd2 !== exp_ready(1'b1)) begin
            errors++;
            $display("FAIL b2b_ready: ready1=%h ready2=%h want %h", rd1, rd2, exp_ready(1'b1));
        end
        gap = 0;
        for (int i = len; i >= 0 && tx1[i] === 1'b1; i--) gap++;
        for (int i = 0; i <= len && tx2[i] === 1'b1; i++) gap++;
        checks++;
        if (gap != CPB + 1) begin
            errors++;
            $display("FAIL b2b_idle_high: got %0d cycles want %0d", gap, CPB + 1);
        end
    endtask

    task automatic test_mid_frame();
        logic [0:127] tx, bz, rd;
        logic [15:0] decoded;
        bit ok, extra;
        accept_word(16'h1234, 1'b0, ok);
        fork
            capture(1'b0, frame_len(1'b1), tx, bz, rd);
            begin
                repeat (26) @(negedge clk);
                in_word = 16'hFFFF; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end
        join
        for (int k = 0; k < 16; k++) decoded[k] = tx[1 + (k + 1) * CPB + CPB / 2];
        checks++;
        if (!ok || decoded !== 16'h1234 || tx !== exp_stream(16'h1234, 1'b1)) begin
            errors++;
            $display("FAIL midframe_decode: got %h want 1234", decoded);
        end
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL midframe_extra: extra frame started, want none"); end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:127] tx, bz, rd;
        bit ok, resumed;
        accept_word(16'hBEEF, 1'b0, ok);
        repeat (38) @(negedge clk);
        checks++;
        if (tx_line !== 1'b0) begin errors++; $display("FAIL rstmid_bit8: tx=%b want 0", tx_line); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: tx=%b busy=%b ready=%b want 1 0 1", tx_line, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        resumed = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_line !== 1'b1 || in_ready !== 1'b1) resumed = 1'b1;
        end
        checks++;
        if (resumed) begin errors++; $display("FAIL rstmid_resume: partial frame resumed, want idle"); end
        accept_word(16'h0F0F, 1'b0, ok);
        capture(1'b0, frame_len(1'b1), tx, bz, rd);
        checks++;
        if (!ok || tx !== exp_stream(16'h0F0F, 1'b1) || bz !== exp_busy(1'b1)) begin
            errors++;
            $display("FAIL rstmid_next: got %h want %h", tx, exp_stream(16'h0F0F, 1'b1));
        end
    endtask

    task automatic test_random();
        logic [0:127] tx, bz, rd;
        logic [15:0] w;
        bit ok, np;
        for (int n = 0; n < 8; n++) begin
            w = 16'($urandom);
            np = n[0];
            accept_word(w, np, ok);
            capture(np, frame_len(!np), tx, bz, rd);
            checks++;
            if (!ok || tx !== exp_stream(w, !np) || bz !== exp_busy(!np)) begin
                errors++;
                $display("FAIL random_frame: word=%h np=%b got %h want %h", w, np, tx, exp_stream(w, !np));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_mid_frame();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
